pm_fetch_sequencer: RTL and testbench

- Program-memory fetch sequencer for the 4-bit micro-processor.
- Owns the program counter register and drives the program-memory address and fetch request.
- Captures the returned instruction byte and presents it to the decoder for one cycle.
- Computes the next PC from the decoder's control strobes (sequential, jump, call, return) using a small hardware return stack.

---
 rtl/pm_fetch_sequencer.sv | 139 +++++++++++++
 tb/tb_pm_fetch_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pm_fetch_sequencer.sv
// Program-memory fetch sequencer: owns the PC, issues fetches, captures the
// instruction byte and computes the next PC with a small hardware return stack.
module pm_fetch_sequencer #(
    parameter int unsigned       ADDR_W      = 4,
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              en_i,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              jmp_i,
    input  logic              call_i,
    input  logic              ret_i,
    input  logic [ADDR_W-1:0] jmp_addr_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              fetch_req_o,
    output logic [DATA_W-1:0] instr_o,
    output logic              instr_valid_o,
    output logic              stack_ovf_o,
    output logic              stack_unf_o
);

    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned SP_W  = IDX_W + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              fetch_req_q, instr_valid_q;

    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic              push_en;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;
    logic [ADDR_W-1:0] pc_inc;
    logic              stack_full;
    logic              stack_empty;

    assign pc_inc      = pc_q + ADDR_W'(1);
    assign push_idx    = sp_q[IDX_W-1:0];
    assign pop_idx     = IDX_W'(sp_q - SP_W'(1));
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);

    // Next-state and next-PC; decoder strobes only matter in ISSUE (ret > call > jmp)
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (en_i) state_d = FETCH;
            end
            FETCH: begin
                if (mem_ack_i) begin
                    instr_d = mem_data_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = en_i ? FETCH : IDLE;
                if (ret_i) begin
                    if (stack_empty) begin
                        unf_d = 1'b1;
                        pc_d  = pc_inc;
                    end else begin
                        pc_d = stack_q[pop_idx];
                        sp_d = sp_q - SP_W'(1);
                    end
                end else if (call_i) begin
                    if (stack_full) begin
                        ovf_d = 1'b1;
                        pc_d  = pc_inc;
                    end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + SP_W'(1);
                        pc_d    = jmp_addr_i;
                    end
                end else if (jmp_i) begin
                    pc_d = jmp_addr_i;
                end else begin
                    pc_d = pc_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            pc_q          <= RESET_VEC;
            instr_q       <= '0;
            sp_q          <= '0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
            fetch_req_q   <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            sp_q          <= sp_d;
            ovf_q         <= ovf_d;
            unf_q         <= unf_d;
            fetch_req_q   <= (state_d == FETCH);
            instr_valid_q <= (state_d == ISSUE);
        end
    end

    // Return-stack storage; contents need no reset since sp gates every read
    always_ff @(posedge clk_i) begin
        if (push_en) stack_q[push_idx] <= pc_inc;
    end

    assign pc_o          = pc_q;
    assign fetch_req_o   = fetch_req_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = instr_valid_q;
    assign stack_ovf_o   = ovf_q;
    assign stack_unf_o   = unf_q;

endmodule

// File: tb/tb_pm_fetch_sequencer.sv
// Directed bench for pm_fetch_sequencer: sequential run, wait states, jumps,
// return-stack boundaries, simultaneous strobes, reset mid-fetch, en handling.
module tb_pm_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset_i, en_i, mem_ack_i, jmp_i, call_i, ret_i;
    logic [7:0] mem_data_i;
    logic [3:0] jmp_addr_i;
    logic [3:0] pc_o;
    logic       fetch_req_o, instr_valid_o, stack_ovf_o, stack_unf_o;
    logic [7:0] instr_o;

    int n_checks = 0;
    int n_pass   = 0;

    pm_fetch_sequencer dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .en_i          (en_i),
        .mem_ack_i     (mem_ack_i),
        .mem_data_i    (mem_data_i),
        .jmp_i         (jmp_i),
        .call_i        (call_i),
        .ret_i         (ret_i),
        .jmp_addr_i    (jmp_addr_i),
        .pc_o          (pc_o),
        .fetch_req_o   (fetch_req_o),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .stack_ovf_o   (stack_ovf_o),
        .stack_unf_o   (stack_unf_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dat(input logic [3:0] p);
        return {~p, p};
    endfunction

    // One instruction starting in its first FETCH cycle: optional wait states,
    // ack with data d, then the ISSUE cycle carrying the given strobes.
    task automatic do_instr(input logic [3:0] p, input int waits, input logic [7:0] d,
                            input logic r, input logic c, input logic j, input logic [3:0] a);
        chk("fetch_req_on", 32'(fetch_req_o), 32'd1);
        chk("pc", 32'(pc_o), 32'(p));
        chk("ivalid_low", 32'(instr_valid_o), 32'd0);
        for (int w = 0; w < waits; w++) begin
            mem_ack_i = 1'b0;
            tick();
            chk("wait_fetch_req", 32'(fetch_req_o), 32'd1);
            chk("wait_pc", 32'(pc_o), 32'(p));
        end
        mem_ack_i  = 1'b1;
        mem_data_i = d;
        tick();
        mem_ack_i  = 1'b0;
        jmp_i      = 1'b0;
        chk("ivalid_high", 32'(instr_valid_o), 32'd1);
        chk("instr", 32'(instr_o), 32'(d));
        chk("fetch_req_issue", 32'(fetch_req_o), 32'd0);
        ret_i      = r;
        call_i     = c;
        jmp_i      = j;
        jmp_addr_i = a;
        tick();
        ret_i  = 1'b0;
        call_i = 1'b0;
        jmp_i  = 1'b0;
    endtask

    initial begin
        reset_i    = 1'b1;
        en_i       = 1'b0;
        mem_ack_i  = 1'b0;
        mem_data_i = 8'h00;
        jmp_i      = 1'b0;
        call_i     = 1'b0;
        ret_i      = 1'b0;
        jmp_addr_i = 4'h0;
        tick();
        tick();
        chk("rst_pc", 32'(pc_o), 32'd0);
        chk("rst_fetch_req", 32'(fetch_req_o), 32'd0);
        chk("rst_ivalid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", 32'(instr_o), 32'd0);
        chk("rst_ovf", 32'(stack_ovf_o), 32'd0);
        chk("rst_unf", 32'(stack_unf_o), 32'd0);

        // Sequential run through the whole address space and wrap
        reset_i = 1'b0;
        en_i    = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            do_instr(4'(i), 0, dat(4'(i)), 1'b0, 1'b0, 1'b0, 4'h0);
        end

        // Call / return / jump
        do_instr(4'd0, 0, dat(4'd0), 1'b0, 1'b0, 1'b0, 4'h0);
        do_instr(4'd1, 0, dat(4'd1), 1'b0, 1'b0, 1'b0, 4'h0);
        do_instr(4'd2, 0, dat(4'd2), 1'b0, 1'b1, 1'b0, 4'd9);
        do_instr(4'd9, 0, dat(4'd9), 1'b1, 1'b0, 1'b0, 4'h0);
        do_instr(4'd3, 0, dat(4'd3), 1'b0, 1'b0, 1'b0, 4'h0);
        do_instr(4'd4, 0, dat(4'd4), 1'b0, 1'b0, 1'b1, 4'd14);
        do_instr(4'd14, 0, dat(4'd14), 1'b0, 1'b0, 1'b1, 4'd5);

        // Wait states at pc=5 with a stray jmp strobe held outside ISSUE
        jmp_i      = 1'b1;
        jmp_addr_i = 4'hF;
        do_instr(4'd5, 3, 8'hA7, 1'b0, 1'b0, 1'b0, 4'h0);

        // Five nested calls: the fifth overflows
        do_instr(4'd6, 0, dat(4'd6), 1'b0, 1'b1, 1'b0, 4'd1);
        do_instr(4'd1, 0, dat(4'd1), 1'b0, 1'b1, 1'b0, 4'd2);
        do_instr(4'd2, 0, dat(4'd2), 1'b0, 1'b1, 1'b0, 4'd3);
        do_instr(4'd3, 0, dat(4'd3), 1'b0, 1'b1, 1'b0, 4'd4);
        chk("ovf_before", 32'(stack_ovf_o), 32'd0);
        do_instr(4'd4, 0, dat(4'd4), 1'b0, 1'b1, 1'b0, 4'd10);
        chk("ovf_set", 32'(stack_ovf_o), 32'd1);

        // Unwind LIFO, then one ret too many
        do_instr(4'd5, 0, dat(4'd5), 1'b1, 1'b0, 1'b0, 4'h0);
        do_instr(4'd4, 0, dat(4'd4), 1'b1, 1'b0, 1'b0, 4'h0);
        do_instr(4'd3, 0, dat(4'd3), 1'b1, 1'b0, 1'b0, 4'h0);
        do_instr(4'd2, 0, dat(4'd2), 1'b1, 1'b0, 1'b0, 4'h0);
        chk("unf_before", 32'(stack_unf_o), 32'd0);
        do_instr(4'd7, 0, dat(4'd7), 1'b1, 1'b0, 1'b0, 4'h0);
        chk("unf_set", 32'(stack_unf_o), 32'd1);
        chk("ovf_sticky", 32'(stack_ovf_o), 32'd1);
        do_instr(4'd8, 0, dat(4'd8), 1'b0, 1'b0, 1'b1, 4'd7);
        chk("unf_sticky", 32'(stack_unf_o), 32'd1);

        // Reset while fetching at pc=7
        chk("pre_rst_pc", 32'(pc_o), 32'd7);
        chk("pre_rst_fetch", 32'(fetch_req_o), 32'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        en_i    = 1'b0;
        chk("mid_rst_pc", 32'(pc_o), 32'd0);
        chk("mid_rst_fetch", 32'(fetch_req_o), 32'd0);
        chk("mid_rst_ovf", 32'(stack_ovf_o), 32'd0);
        chk("mid_rst_unf", 32'(stack_unf_o), 32'd0);
        chk("mid_rst_instr", 32'(instr_o), 32'd0);
        tick();
        chk("idle_hold_fetch", 32'(fetch_req_o), 32'd0);
        en_i = 1'b1;
        tick();

        // Simultaneous strobes: only ret acts, so the next ret underflows
        do_instr(4'd0, 0, dat(4'd0), 1'b0, 1'b1, 1'b0, 4'd6);
        do_instr(4'd6, 0, dat(4'd6), 1'b1, 1'b1, 1'b1, 4'd13);
        chk("simul_unf_clear", 32'(stack_unf_o), 32'd0);
        do_instr(4'd1, 0, dat(4'd1), 1'b1, 1'b0, 1'b0, 4'h0);
        chk("simul_unf_set", 32'(stack_unf_o), 32'd1);
        chk("simul_ovf_clear", 32'(stack_ovf_o), 32'd0);

        // Drop en during FETCH: fetch completes, ISSUE, then park in IDLE
        chk("en_fetch", 32'(fetch_req_o), 32'd1);
        chk("en_pc", 32'(pc_o), 32'd2);
        en_i = 1'b0;
        tick();
        chk("en_fetch_held", 32'(fetch_req_o), 32'd1);
        mem_ack_i  = 1'b1;
        mem_data_i = 8'h3C;
        tick();
        mem_ack_i = 1'b0;
        chk("en_issue_valid", 32'(instr_valid_o), 32'd1);
        chk("en_issue_instr", 32'(instr_o), 32'h3C);
        tick();
        chk("en_idle_fetch", 32'(fetch_req_o), 32'd0);
        chk("en_idle_valid", 32'(instr_valid_o), 32'd0);
        chk("en_idle_pc", 32'(pc_o), 32'd3);

        // mem_ack in IDLE must not capture data
        mem_ack_i  = 1'b1;
        mem_data_i = 8'h55;
        tick();
        mem_ack_i = 1'b0;
        chk("idle_ack_instr", 32'(instr_o), 32'h3C);
        chk("idle_ack_valid", 32'(instr_valid_o), 32'd0);
        chk("idle_ack_fetch", 32'(fetch_req_o), 32'd0);
        chk("idle_ack_pc", 32'(pc_o), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
